shift_unit: RTL and testbench



---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_step.sv | 38 +++
 rtl/shift_unit.sv | 113 +++++++++++
 tb/tb_shift_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and defaults for the multi-cycle shifter: op encoding, FSM states,
// and the default operand width and per-cycle step size.
package shift_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_STEP  = 4;

   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10,
      SH_ROR = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a value by k (0..STEP) bits in one cycle.
// Rotate-right support for SH_ROR is compiled in only when SHIFT_UNIT_ROTATE_EN is defined.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int STEP  = DEFAULT_STEP,
   localparam int KW   = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] value_i,
   input  shift_op_e        op_i,
   input  logic             fill_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH-1:0] value_o
);

   logic [WIDTH-1:0] fillMask;

   // The fill mask covers exactly the k MSB positions vacated by a right shift.
   always_comb begin
      fillMask = ~({WIDTH{1'b1}} >> k_i);
      value_o  = value_i;
      case (op_i)
         SH_SLL: value_o = value_i << k_i;
         SH_SRL: value_o = value_i >> k_i;
         SH_SRA: value_o = (value_i >> k_i) | (fill_i ? fillMask : '0);
         SH_ROR: begin
`ifdef SHIFT_UNIT_ROTATE_EN
            value_o = (value_i >> k_i) | (value_i << (WIDTH - int'(k_i)));
`else
            value_o = value_i;
`endif
         end
         default: value_o = value_i;
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter with valid/ready handshakes, up to STEP bits per cycle.
// Define SHIFT_UNIT_ROTATE_EN to make op=11 a rotate right; otherwise it passes data through.
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int STEP  = DEFAULT_STEP,
   localparam int SHW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             busy
);

   localparam int KW = $clog2(STEP + 1);
   localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

   shift_state_e     state_q, state_d;
   shift_op_e        op_q, op_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   remain_q, remain_d;
   logic             sign_q, sign_d;

   logic [SHW-1:0]   shamtEff;
   logic [SHW:0]     kWide;
   logic [WIDTH-1:0] stepped;

   // Without rotate support, op=11 completes immediately as a pass-through.
   always_comb begin
`ifdef SHIFT_UNIT_ROTATE_EN
      shamtEff = shamt;
`else
      shamtEff = (op == SH_ROR) ? '0 : shamt;
`endif
      kWide = ({1'b0, remain_q} < STEP_W) ? {1'b0, remain_q} : STEP_W;
   end

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .value_i (work_q),
      .op_i    (op_q),
      .fill_i  (sign_q),
      .k_i     (kWide[KW-1:0]),
      .value_o (stepped)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= SH_SLL;
         work_q   <= '0;
         remain_q <= '0;
         sign_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         remain_q <= remain_d;
         sign_q   <= sign_d;
      end
   end

   // The SRA fill comes from the sign bit captured at accept, not the evolving register.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      remain_d = remain_q;
      sign_d   = sign_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d     = shift_op_e'(op);
               work_d   = data_in;
               remain_d = shamtEff;
               sign_d   = data_in[WIDTH-1];
               state_d  = (shamtEff == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            work_d   = stepped;
            remain_d = remain_q - kWide[SHW-1:0];
            if (remain_q == kWide[SHW-1:0]) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      data_out  = work_q;
   end

endmodule

// File: tb/tb_shift_unit.sv
// Directed, table-driven bench for shift_unit (WIDTH=32, STEP=4); rotate vectors
// follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] data;
      logic [4:0]  shamt;
      logic [31:0] expData;
      int          expLat;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic        busy;

   int testCount;
   int failCount;

   vec_t vectors[12];

   shift_unit #(
      .WIDTH (32),
      .STEP  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .data_in   (data_in),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   // Free-running clock; all sampling happens on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence stalls outside its own bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Presents one request, measures edges until out_valid, then completes the handshake.
   task automatic applyStimulus(input vec_t v);
      int lat;
      in_valid = 1'b1;
      op       = v.op;
      data_in  = v.data;
      shamt    = v.shamt;
      checkOutput({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      checkOutput({v.name, " busy after accept"}, 32'(busy), 32'd1);
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      checkOutput({v.name, " latency"}, 32'(lat), 32'(v.expLat));
      checkOutput({v.name, " data"}, data_out, v.expData);
      checkOutput({v.name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({v.name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
      checkOutput({v.name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int waitCycles;
      testCount = 0;
      failCount = 0;

      vectors[0]  = '{"sll_1_by_2",      2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 2};
      vectors[1]  = '{"sra_min_by_31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9};
      vectors[2]  = '{"srl_min_by_31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9};
      vectors[3]  = '{"sll_by_0",        2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
      vectors[4]  = '{"srl_by_8",        2'b01, 32'hF000_0000, 5'd8,  32'h00F0_0000, 3};
      vectors[5]  = '{"sra_pos_by_4",    2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000, 2};
      vectors[6]  = '{"sra_neg_by_5",    2'b10, 32'hF000_0000, 5'd5,  32'hFF80_0000, 3};
      vectors[7]  = '{"sll_by_31",       2'b00, 32'h1234_5679, 5'd31, 32'h8000_0000, 9};
      vectors[8]  = '{"sll_by_16",       2'b00, 32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 5};
      vectors[9]  = '{"srl_by_3",        2'b01, 32'h1234_5678, 5'd3,  32'h0246_8ACF, 2};
`ifdef SHIFT_UNIT_ROTATE_EN
      vectors[10] = '{"ror_1_by_1",      2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 2};
      vectors[11] = '{"ror_f1_by_8",     2'b11, 32'h0000_00F1, 5'd8,  32'hF100_0000, 3};
`else
      vectors[10] = '{"ror_1_by_1",      2'b11, 32'h0000_0001, 5'd1,  32'h0000_0001, 1};
      vectors[11] = '{"ror_f1_by_8",     2'b11, 32'h0000_00F1, 5'd8,  32'h0000_00F1, 1};
`endif

      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 2'b00;
      data_in   = '0;
      shamt     = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset data_out", data_out, 32'h0);

      // Back-to-back: each request is presented on the cycle right after the previous handshake.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vectors[i]);
      end

      // Result held under back-pressure while new requests are ignored.
      in_valid = 1'b1;
      op       = 2'b01;
      data_in  = 32'hF000_0000;
      shamt    = 5'd8;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      waitCycles = 1;
      while (!out_valid && waitCycles < 40) begin
         @(posedge clk);
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("stall latency", 32'(waitCycles), 32'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op       = 2'b00;
         data_in  = 32'h0000_0005;
         shamt    = 5'd1;
         checkOutput("stall out_valid", 32'(out_valid), 32'd1);
         checkOutput("stall data_out", data_out, 32'h00F0_0000);
         checkOutput("stall in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("stall data_out end", data_out, 32'h00F0_0000);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("stall released busy", 32'(busy), 32'd0);
      checkOutput("stall released in_ready", 32'(in_ready), 32'd1);

      // Reset during the third SHIFT cycle discards the in-flight result.
      in_valid = 1'b1;
      op       = 2'b00;
      data_in  = 32'h0000_0001;
      shamt    = 5'd20;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("pre-reset busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort data_out", data_out, 32'h0);
      checkOutput("abort in_ready", 32'(in_ready), 32'd1);
      checkOutput("abort busy", 32'(busy), 32'd0);
      applyStimulus('{"sll_after_abort", 2'b00, 32'h0000_0001, 5'd20, 32'h0010_0000, 6});

      // Reset takes priority over a simultaneous request.
      rst      = 1'b1;
      in_valid = 1'b1;
      op       = 2'b00;
      data_in  = 32'h0000_0003;
      shamt    = 5'd0;
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("reset-vs-valid busy", 32'(busy), 32'd0);
      checkOutput("reset-vs-valid out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset-vs-valid data_out", data_out, 32'h0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
